// File: rtl/l2_mem_pkg.sv
// Shared types and default sizing for the L2 <-> memory link controller.
package l2_mem_pkg;

  localparam int unsigned LINE_W        = 128;
  localparam int unsigned GID_W         = 3;
  localparam int unsigned FILL_LAT_DEF  = 4;
  localparam int unsigned WB_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_TURN,
    ST_FILL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/l2_mem_ctrl.sv
// Serialises L2 line fills and dirty write-backs onto the shared L2<->memory bus.
module l2_mem_ctrl
  import l2_mem_pkg::*;
#(
  parameter int unsigned FILL_LAT  = FILL_LAT_DEF,
  parameter int unsigned WB_CYCLES = WB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_req,
  input  logic [GID_W-1:0]  fill_gid,
  output logic              fill_ack,
  input  logic              wb_req,
  input  logic [GID_W-1:0]  wb_gid,
  input  logic [LINE_W-1:0] wb_data,
  output logic              wb_ack,
  output logic              fill_valid,
  output logic [LINE_W-1:0] fill_data,
  output logic              fill_err,
  output logic              l2_miss,
  output logic              en_back,
  output logic [GID_W-1:0]  group_id,
  inout  wire  [LINE_W-1:0] data,
  input  logic              error
);

  localparam int unsigned CNT_MAX = (FILL_LAT > WB_CYCLES) ? FILL_LAT : WB_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [LINE_W-1:0]   wb_line;

  // Bus is driven only from registered state, so release is glitch-free after WB.
  assign data = en_back ? wb_line : 'z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wb_line    <= '0;
      fill_ack   <= 1'b0;
      wb_ack     <= 1'b0;
      fill_valid <= 1'b0;
      fill_data  <= '0;
      fill_err   <= 1'b0;
      l2_miss    <= 1'b0;
      en_back    <= 1'b0;
      group_id   <= '0;
    end else begin
      fill_ack   <= 1'b0;
      wb_ack     <= 1'b0;
      fill_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          // Write-back wins so a fill can never return a line older than memory's copy.
          if (wb_req) begin
            wb_line  <= wb_data;
            wb_ack   <= 1'b1;
            en_back  <= 1'b1;
            group_id <= wb_gid;
            state    <= ST_WB;
          end else if (fill_req) begin
            fill_ack <= 1'b1;
            l2_miss  <= 1'b1;
            group_id <= fill_gid;
            state    <= ST_FILL;
          end
        end
        ST_WB: begin
          if (cnt == CNT_W'(WB_CYCLES - 1)) begin
            cnt      <= '0;
            en_back  <= 1'b0;
            group_id <= '0;
            state    <= ST_TURN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_TURN: begin
          state <= ST_IDLE;
        end
        ST_FILL: begin
          if (cnt == CNT_W'(FILL_LAT - 1)) begin
            cnt        <= '0;
            fill_data  <= data;
            fill_err   <= error;
            fill_valid <= 1'b1;
            l2_miss    <= 1'b0;
            group_id   <= '0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Randomised transaction bench for l2_mem_ctrl with a timing-rule reference model.
module tb_l2_mem_ctrl;
  import l2_mem_pkg::*;

  localparam int unsigned FL  = 4;
  localparam int unsigned WBC = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              fill_req;
  logic [GID_W-1:0]  fill_gid;
  logic              fill_ack;
  logic              wb_req;
  logic [GID_W-1:0]  wb_gid;
  logic [LINE_W-1:0] wb_data;
  logic              wb_ack;
  logic              fill_valid;
  logic [LINE_W-1:0] fill_data;
  logic              fill_err;
  logic              l2_miss;
  logic              en_back;
  logic [GID_W-1:0]  group_id;
  wire  [LINE_W-1:0] data;
  logic              error;
  logic [LINE_W-1:0] mem_line;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned contention = 0;
  int unsigned cyc_cnt = 0;

  // Memory side of the bus: drives only while a fill is outstanding.
  assign data = l2_miss ? mem_line : 'z;

  l2_mem_ctrl #(.FILL_LAT(FL), .WB_CYCLES(WBC)) dut (
    .clk(clk), .reset(reset),
    .fill_req(fill_req), .fill_gid(fill_gid), .fill_ack(fill_ack),
    .wb_req(wb_req), .wb_gid(wb_gid), .wb_data(wb_data), .wb_ack(wb_ack),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_err(fill_err),
    .l2_miss(l2_miss), .en_back(en_back), .group_id(group_id),
    .data(data), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) if (en_back && l2_miss) contention <= contention + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_ctl(input string tag, input logic fa, input logic wa, input logic miss,
                            input logic enb, input logic fv, input logic [GID_W-1:0] gid);
    check(tag, 128'({fill_ack, wb_ack, l2_miss, en_back, fill_valid, group_id}),
               128'({fa, wa, miss, enb, fv, gid}));
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_ack(input bit is_wb, output int unsigned at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (is_wb ? wb_ack : fill_ack) begin
        ok = 1'b1;
        at = cyc_cnt;
        break;
      end
    end
    if (!ok) check(is_wb ? "wb_ack_timeout" : "fill_ack_timeout",
                   128'(is_wb ? wb_ack : fill_ack), 128'd1);
  endtask

  // Entered at the ack cycle; returns at the first IDLE cycle after DONE.
  task automatic run_fill(input logic [GID_W-1:0] gid, input logic [127:0] line, input logic err);
    for (int unsigned k = 1; k <= FL; k++) begin
      expect_ctl($sformatf("fill_c%0d", k), k == 1, 1'b0, 1'b1, 1'b0, 1'b0, gid);
      if (k == FL) begin
        mem_line = line;
        error    = err;
      end else begin
        mem_line = rand128();
        error    = 1'($urandom_range(0, 1));
      end
      tick();
    end
    error = 1'b0;
    expect_ctl("fill_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("fill_data", fill_data, line);
    check("fill_err", 128'(fill_err), 128'(err));
    tick();
    expect_ctl("fill_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("fill_data_hold", fill_data, line);
  endtask

  // Entered at the ack cycle; returns at the first IDLE cycle after TURN.
  task automatic run_wb(input logic [GID_W-1:0] gid, input logic [127:0] line);
    for (int unsigned k = 1; k <= WBC; k++) begin
      expect_ctl($sformatf("wb_c%0d", k), 1'b0, k == 1, 1'b0, 1'b1, 1'b0, gid);
      check($sformatf("wb_bus_c%0d", k), data, line);
      tick();
    end
    expect_ctl("wb_turn", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic do_fill(input logic [GID_W-1:0] gid, input logic [127:0] line, input logic err);
    int unsigned t0, at;
    bit ok;
    fill_req = 1'b1;
    fill_gid = gid;
    t0 = cyc_cnt;
    wait_ack(1'b0, at, ok);
    fill_req = 1'b0;
    fill_gid = 3'($urandom);
    if (ok) begin
      check("fill_ack_lat", 128'(at - t0), 128'd1);
      run_fill(gid, line, err);
    end
  endtask

  task automatic do_wb(input logic [GID_W-1:0] gid, input logic [127:0] line);
    int unsigned t0, at;
    bit ok;
    wb_req  = 1'b1;
    wb_gid  = gid;
    wb_data = line;
    t0 = cyc_cnt;
    wait_ack(1'b1, at, ok);
    wb_req  = 1'b0;
    wb_gid  = 3'($urandom);
    wb_data = rand128();
    if (ok) begin
      check("wb_ack_lat", 128'(at - t0), 128'd1);
      run_wb(gid, line);
    end
  endtask

  task automatic do_both(input logic [GID_W-1:0] wg, input logic [127:0] wl,
                         input logic [GID_W-1:0] fg, input logic [127:0] fl, input logic err);
    int unsigned t0, at_w, at_f;
    bit ok;
    wb_req   = 1'b1;
    wb_gid   = wg;
    wb_data  = wl;
    fill_req = 1'b1;
    fill_gid = fg;
    t0 = cyc_cnt;
    wait_ack(1'b1, at_w, ok);
    wb_req  = 1'b0;
    wb_data = rand128();
    if (ok) begin
      check("both_wb_lat", 128'(at_w - t0), 128'd1);
      run_wb(wg, wl);
      wait_ack(1'b0, at_f, ok);
      fill_req = 1'b0;
      if (ok) begin
        check("both_fill_gap", 128'(at_f - at_w), 128'(WBC + 2));
        run_fill(fg, fl, err);
      end
    end
    fill_req = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      expect_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick();
    end
  endtask

  initial begin
    int unsigned at;
    bit ok;
    reset    = 1'b1;
    fill_req = 1'b0;
    fill_gid = '0;
    wb_req   = 1'b0;
    wb_gid   = '0;
    wb_data  = '0;
    error    = 1'b0;
    mem_line = '0;

    tick();
    expect_ctl("rst_ctl", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("rst_fill_data", fill_data, '0);
    check("rst_fill_err", 128'(fill_err), 128'd0);
    reset = 1'b0;
    idle_cycles(3, "rst_idle");

    do_fill(3'd0, 128'h0123456789abcdef0123456789abcdef, 1'b0);
    do_wb(3'd2, 128'haaaaaaaa_fafafafa_ffffffff_afafafaf);
    do_both(3'd2, rand128(), 3'd1, rand128(), 1'b0);
    do_fill(3'd3, rand128(), 1'b1);
    do_fill(3'd5, rand128(), 1'b0);

    // Reset in the second FILL cycle: outputs drop before the next edge.
    fill_req = 1'b1;
    fill_gid = 3'd6;
    wait_ack(1'b0, at, ok);
    fill_req = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1 expect_ctl("rst_mid_fill", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    reset = 1'b0;
    check("rst_mid_fill_data", fill_data, '0);
    idle_cycles(FL + 2, "rst_fill_quiet");
    do_fill(3'd6, rand128(), 1'b0);

    // Reset while write-back data is on the bus.
    wb_req  = 1'b1;
    wb_gid  = 3'd4;
    wb_data = rand128();
    wait_ack(1'b1, at, ok);
    wb_req = 1'b0;
    #2 reset = 1'b1;
    #1 expect_ctl("rst_mid_wb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    reset = 1'b0;
    idle_cycles(WBC + 2, "rst_wb_quiet");

    for (int t = 0; t < 40; t++) begin
      int unsigned kind;
      kind = $urandom_range(0, 2);
      case (kind)
        0: do_fill(3'($urandom), rand128(), 1'($urandom_range(0, 1)));
        1: do_wb(3'($urandom), rand128());
        default: do_both(3'($urandom), rand128(), 3'($urandom), rand128(), 1'($urandom_range(0, 1)));
      endcase
      idle_cycles($urandom_range(0, 2), "rand_gap");
    end

    check("bus_contention", 128'(contention), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_mem_ctrl.md
# l2_mem_ctrl

L2-side controller for the L2↔memory link: issues line fills to the `memory` block (`l2_miss`) and drives dirty-line write-backs onto the shared 128-bit bidirectional bus (`en_back`). It accepts fill and write-back requests from the L2 miss logic, serialises them onto the single bus, and returns fill data with error status. It is the initiator and bus-driving end of the interface that `memory` responds to.

## Interface
- `FILL_LAT`, 4: cycles from `l2_miss` assertion to the cycle where the fill line is sampled from `data` (≥2).
- `WB_CYCLES`, 2: cycles `en_back` is held with write-back data driven.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `fill_req`  in  1  L2 requests a line fill; held until `fill_ack`.
- `fill_gid`  in  3  group id of the fill.
- `fill_ack`  out  1  one-cycle pulse: fill request accepted.
- `wb_req`  in  1  L2 requests write-back; held until `wb_ack`.
- `wb_gid`  in  3  group id of the write-back.
- `wb_data`  in  128  write-back line.
- `wb_ack`  out  1  one-cycle pulse: write-back accepted, `wb_data` latched.
- `fill_valid`  out  1  one-cycle pulse: `fill_data` and `fill_err` valid.
- `fill_data`  out  128  captured fill line; held until next capture.
- `fill_err`  out  1  `error` from memory at capture cycle.
- `l2_miss`  out  1  to memory: fill in progress.
- `en_back`  out  1  to memory: write-back data on bus.
- `group_id`  out  3  to memory: group of current transfer.
- `data`  inout  128  shared bus; driven by this block only while `en_back`=1, else `'z`.
- `error`  in  1  memory error flag.

## Operation
- FSM states: IDLE, WB, TURN, FILL, DONE.
- IDLE: if `wb_req` → latch `wb_gid`/`wb_data`, pulse `wb_ack`, go WB. Else if `fill_req` → latch `fill_gid`, pulse `fill_ack`, go FILL. Write-back has priority when both are pending (stale-read avoidance).
- WB: `en_back`=1, `group_id`=latched wb gid, bus = latched data, for `WB_CYCLES` cycles; then TURN.
- TURN: one cycle, bus released, all memory-side outputs low; then IDLE. Guarantees no drive overlap with memory.
- FILL: `l2_miss`=1, `group_id`=fill gid; counter runs 0..`FILL_LAT`-1; on the last count sample `data` into `fill_data` and `error` into `fill_err`; go DONE.
- DONE: `fill_valid`=1 for one cycle, `l2_miss`=0; go IDLE.
- `fill_err`=1 still completes normally; no retry in this block.
- `group_id` = 0 in IDLE/TURN/DONE.

## Timing
- Reset values: `fill_ack`/`wb_ack`/`fill_valid`/`fill_err`/`l2_miss`/`en_back`=0, `group_id`=0, `fill_data`=0, bus `'z`, state IDLE, counter 0.
- All outputs are registered; `data` is driven from the registered `en_back` and the latched line.
- Acks are asserted in the cycle the state leaves IDLE; the requester drops its request the cycle after the ack.
- Fill latency: `fill_req` sampled at edge N → `l2_miss` high N+1..N+`FILL_LAT` → `fill_valid` at N+`FILL_LAT`+1.
- Write-back: `en_back` high N+1..N+`WB_CYCLES`; next request accepted at the earliest at N+`WB_CYCLES`+2.
- Back-to-back WB then fill: the fill `l2_miss` rises no earlier than 2 cycles after `en_back` falls.
- Asynchronous reset mid-transfer: `en_back`/`l2_miss` drop and the bus releases immediately, with no `fill_valid`. The pending request is lost, and the requester reissues it.

## Structure
- Shared package `l2_mem_pkg`: state enum, `LINE_W`=128, `GID_W`=3, default `FILL_LAT`/`WB_CYCLES`.
- A single module is sufficient. The latency counter is inline; no sub-module is needed.

## Test plan
- Reset: `reset`=1 for 1 cycle → all outputs 0, `data`=z; release with no requests → remains IDLE.
- Fill: `fill_req`, gid 0, memory returns 128'h0123…cdef → `fill_ack` at +1, `l2_miss` for 4 cycles, `fill_valid`=1 with that data and `fill_err`=0.
- Write-back: `wb_req`, gid 2, data 128'haaaaaaaa_fafafafa_ffffffff_afafafaf → `en_back`=1 for 2 cycles with that value on `data`, `group_id`=2, followed by 1 TURN cycle with `data`=z.
- Simultaneous `wb_req` (gid 2) and `fill_req` (gid 1) → WB first; `fill_ack` 4 cycles after `wb_ack`; a bus-contention checker reports no X on `data`.
- Error: memory raises `error` on the fill capture cycle → `fill_valid`=1 with `fill_err`=1; the next fill has `fill_err`=0.
- Reset asserted during the 2nd FILL cycle → `l2_miss`=0 immediately, no `fill_valid`; a fresh fill completes normally.
